// File: rtl/fighter_pkg.sv
// Shared attack codes, hurt-state encoding and widths for the fighter player blocks.
package fighter_pkg;

    localparam int unsigned HEALTH_W = 7;
    localparam int unsigned FRAME_W  = 6;

    localparam logic [1:0] ATK_NONE = 2'd0;
    localparam logic [1:0] ATK1     = 2'd1;
    localparam logic [1:0] ATK2     = 2'd2;

    typedef enum logic [2:0] {
        HS_IDLE      = 3'd0,
        HS_HITSTUN   = 3'd1,
        HS_BLOCKSTUN = 3'd2,
        HS_INVULN    = 3'd3,
        HS_KO        = 3'd4
    } hurt_state_e;

    // Codes 0 and 3 carry no attack and never resolve into a hit.
    function automatic logic is_attack(input logic [1:0] atk_type);
        return (atk_type == ATK1) || (atk_type == ATK2);
    endfunction

endpackage

// File: rtl/hit_damage_lut.sv
// Combinational damage resolution: attack type, block flag and current health
// to post-hit health, stun length and KO indication.
module hit_damage_lut
    import fighter_pkg::*;
#(
    parameter int unsigned ATK1_DAMAGE  = 8,
    parameter int unsigned ATK2_DAMAGE  = 15,
    parameter int unsigned ATK1_HITSTUN = 12,
    parameter int unsigned ATK2_HITSTUN = 20,
    parameter int unsigned BLOCKSTUN    = 6
) (
    input  logic [1:0]          atk_type_i,
    input  logic                blocking_i,
    input  logic [HEALTH_W-1:0] health_i,
    output logic [HEALTH_W-1:0] new_health_o,
    output logic [FRAME_W-1:0]  stun_len_o,
    output logic                ko_next_o
);

    logic [HEALTH_W-1:0] dmg;
    logic [HEALTH_W-1:0] chip;

    always_comb begin
        dmg          = (atk_type_i == ATK2) ? HEALTH_W'(ATK2_DAMAGE) : HEALTH_W'(ATK1_DAMAGE);
        chip         = dmg >> 2;
        new_health_o = health_i;
        ko_next_o    = 1'b0;
        stun_len_o   = (atk_type_i == ATK2) ? FRAME_W'(ATK2_HITSTUN) : FRAME_W'(ATK1_HITSTUN);

        if (blocking_i) begin
            // Chip damage can bring health down to 1 but never finishes the player.
            new_health_o = (health_i > chip) ? health_i - chip : HEALTH_W'(1);
            stun_len_o   = FRAME_W'(BLOCKSTUN);
        end else if (health_i <= dmg) begin
            new_health_o = '0;
            ko_next_o    = 1'b1;
        end else begin
            new_health_o = health_i - dmg;
        end
    end

endmodule

// File: rtl/player_hit_receiver.sv
// Resolves opponent attack instances into hits or blocks and tracks health,
// hitstun/blockstun/invulnerability timers and KO for one player.
module player_hit_receiver
    import fighter_pkg::*;
#(
    parameter int unsigned MAX_HEALTH    = 100,
    parameter int unsigned ATK1_DAMAGE   = 8,
    parameter int unsigned ATK2_DAMAGE   = 15,
    parameter int unsigned ATK1_HITSTUN  = 12,
    parameter int unsigned ATK2_HITSTUN  = 20,
    parameter int unsigned BLOCKSTUN     = 6,
    parameter int unsigned INVULN_FRAMES = 30
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                SCEN,
    input  logic                hit_enable,
    input  logic                opp_attack_active,
    input  logic [1:0]          opp_attack_type,
    input  logic                overlap,
    input  logic                blocking,
    output logic [HEALTH_W-1:0] health,
    output logic [2:0]          hurt_state,
    output logic [FRAME_W-1:0]  stun_frame,
    output logic                hit_pulse,
    output logic                block_pulse,
    output logic                ko,
    output logic                move_lock
);

    hurt_state_e         state_q,    state_d;
    logic [FRAME_W-1:0]  frame_q,    frame_d;
    logic [FRAME_W-1:0]  stun_len_q, stun_len_d;
    logic [HEALTH_W-1:0] health_q,   health_d;
    logic                consumed_q, consumed_d;
    logic                hit_q,      hit_d;
    logic                block_q,    block_d;
    logic                ko_q,       ko_d;

    logic                tick;
    logic                candidate;
    logic                lands;
    logic [HEALTH_W-1:0] lut_health;
    logic [FRAME_W-1:0]  lut_stun_len;
    logic                lut_ko;

    hit_damage_lut #(
        .ATK1_DAMAGE  (ATK1_DAMAGE),
        .ATK2_DAMAGE  (ATK2_DAMAGE),
        .ATK1_HITSTUN (ATK1_HITSTUN),
        .ATK2_HITSTUN (ATK2_HITSTUN),
        .BLOCKSTUN    (BLOCKSTUN)
    ) u_lut (
        .atk_type_i   (opp_attack_type),
        .blocking_i   (blocking),
        .health_i     (health_q),
        .new_health_o (lut_health),
        .stun_len_o   (lut_stun_len),
        .ko_next_o    (lut_ko)
    );

    assign tick      = SCEN & hit_enable;
    assign candidate = tick & opp_attack_active & overlap & is_attack(opp_attack_type) & ~consumed_q;
    assign lands     = candidate & ((state_q == HS_IDLE) | (state_q == HS_BLOCKSTUN));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= HS_IDLE;
            frame_q    <= '0;
            stun_len_q <= '0;
            health_q   <= HEALTH_W'(MAX_HEALTH);
            consumed_q <= 1'b0;
            hit_q      <= 1'b0;
            block_q    <= 1'b0;
            ko_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            frame_q    <= frame_d;
            stun_len_q <= stun_len_d;
            health_q   <= health_d;
            consumed_q <= consumed_d;
            hit_q      <= hit_d;
            block_q    <= block_d;
            ko_q       <= ko_d;
        end
    end

    // A landing hit takes priority over the timer, so a candidate arriving on an
    // expiry cycle is judged against the state before that expiry.
    always_comb begin
        state_d    = state_q;
        frame_d    = frame_q;
        stun_len_d = stun_len_q;
        health_d   = health_q;
        consumed_d = consumed_q;
        hit_d      = 1'b0;
        block_d    = 1'b0;
        ko_d       = ko_q;

        if (SCEN && !opp_attack_active) begin
            consumed_d = 1'b0;
        end
        if (candidate) begin
            consumed_d = 1'b1;
        end

        if (lands) begin
            health_d   = lut_health;
            frame_d    = '0;
            stun_len_d = lut_stun_len;
            if (blocking) begin
                state_d = HS_BLOCKSTUN;
                block_d = 1'b1;
            end else begin
                hit_d = 1'b1;
                if (lut_ko) begin
                    state_d = HS_KO;
                    ko_d    = 1'b1;
                end else begin
                    state_d = HS_HITSTUN;
                end
            end
        end else if (tick) begin
            unique case (state_q)
                HS_HITSTUN: begin
                    if (frame_q == stun_len_q - FRAME_W'(1)) begin
                        state_d = HS_INVULN;
                        frame_d = '0;
                    end else begin
                        frame_d = frame_q + FRAME_W'(1);
                    end
                end
                HS_BLOCKSTUN: begin
                    if (frame_q == stun_len_q - FRAME_W'(1)) begin
                        state_d = HS_IDLE;
                        frame_d = '0;
                    end else begin
                        frame_d = frame_q + FRAME_W'(1);
                    end
                end
                HS_INVULN: begin
                    if (frame_q == FRAME_W'(INVULN_FRAMES - 1)) begin
                        state_d = HS_IDLE;
                        frame_d = '0;
                    end else begin
                        frame_d = frame_q + FRAME_W'(1);
                    end
                end
                default: begin
                    frame_d = '0;
                end
            endcase
        end
    end

    always_comb begin
        health      = health_q;
        hurt_state  = state_q;
        stun_frame  = frame_q;
        hit_pulse   = hit_q;
        block_pulse = block_q;
        ko          = ko_q;
        move_lock   = (state_q == HS_HITSTUN) || (state_q == HS_BLOCKSTUN) || (state_q == HS_KO);
    end

endmodule

// File: tb/tb_player_hit_receiver.sv
// Directed scenarios plus randomized traffic, checked every cycle against a
// frame-level model of the hit receiver rules.
module tb_player_hit_receiver;

    logic       clk = 1'b0;
    logic       reset;
    logic       SCEN;
    logic       hit_enable;
    logic       opp_attack_active;
    logic [1:0] opp_attack_type;
    logic       overlap;
    logic       blocking;
    logic [6:0] health;
    logic [2:0] hurt_state;
    logic [5:0] stun_frame;
    logic       hit_pulse;
    logic       block_pulse;
    logic       ko;
    logic       move_lock;

    player_hit_receiver #(
        .MAX_HEALTH    (100),
        .ATK1_DAMAGE   (8),
        .ATK2_DAMAGE   (15),
        .ATK1_HITSTUN  (12),
        .ATK2_HITSTUN  (20),
        .BLOCKSTUN     (6),
        .INVULN_FRAMES (30)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .SCEN              (SCEN),
        .hit_enable        (hit_enable),
        .opp_attack_active (opp_attack_active),
        .opp_attack_type   (opp_attack_type),
        .overlap           (overlap),
        .blocking          (blocking),
        .health            (health),
        .hurt_state        (hurt_state),
        .stun_frame        (stun_frame),
        .hit_pulse         (hit_pulse),
        .block_pulse       (block_pulse),
        .ko                (ko),
        .move_lock         (move_lock)
    );

    always #5 clk = ~clk;

    // phase: 0 idle, 1 hitstun, 2 blockstun, 3 invuln, 4 ko
    typedef struct {
        int health;
        int phase;
        int frame;
        int len;
        bit consumed;
        bit hitp;
        bit blkp;
        bit ko;
    } model_t;

    model_t m;
    int tests = 0;
    int fails = 0;
    bit cmp_en = 0;
    int cnt_hs, cnt_bs, cnt_inv, cnt_hit, cnt_blk, cnt_lock;

    function automatic model_t step(model_t c, bit rst, bit scen, bit en, bit act,
                                    logic [1:0] typ, bit ov, bit blk);
        model_t n;
        int dmg;
        bit tk, cand;
        n = c;
        n.hitp = 0;
        n.blkp = 0;
        if (rst) begin
            n.health = 100; n.phase = 0; n.frame = 0; n.len = 0;
            n.consumed = 0; n.ko = 0;
            return n;
        end
        tk   = scen && en;
        cand = tk && act && ov && (typ == 2'd1 || typ == 2'd2) && !c.consumed;
        if (scen && !act) n.consumed = 0;
        if (cand) n.consumed = 1;
        if (cand && (c.phase == 0 || c.phase == 2)) begin
            dmg = (typ == 2'd1) ? 8 : 15;
            n.frame = 0;
            if (blk) begin
                n.health = (c.health - dmg / 4 < 1) ? 1 : c.health - dmg / 4;
                n.phase = 2; n.len = 6; n.blkp = 1;
            end else begin
                n.health = (c.health - dmg < 0) ? 0 : c.health - dmg;
                n.hitp = 1;
                if (n.health == 0) begin
                    n.phase = 4; n.ko = 1;
                end else begin
                    n.phase = 1; n.len = (typ == 2'd1) ? 12 : 20;
                end
            end
        end else if (tk && c.phase >= 1 && c.phase <= 3) begin
            n.frame = c.frame + 1;
            if (n.frame == c.len) begin
                n.frame = 0;
                if (c.phase == 1) begin
                    n.phase = 3; n.len = 30;
                end else begin
                    n.phase = 0;
                end
            end
        end
        return n;
    endfunction

    always @(posedge clk)
        m <= step(m, reset, SCEN, hit_enable, opp_attack_active, opp_attack_type, overlap, blocking);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        check("health", 32'(health), m.health);
        check("hurt_state", 32'(hurt_state), m.phase);
        check("stun_frame", 32'(stun_frame), m.frame);
        check("hit_pulse", 32'(hit_pulse), 32'(m.hitp));
        check("block_pulse", 32'(block_pulse), 32'(m.blkp));
        check("ko", 32'(ko), 32'(m.ko));
        check("move_lock", 32'(move_lock), (m.phase == 1 || m.phase == 2 || m.phase == 4) ? 1 : 0);
    endtask

    // One clock: inputs already set; afterwards outputs reflect that edge.
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
        if (hurt_state == 3'd1) cnt_hs++;
        if (hurt_state == 3'd2) cnt_bs++;
        if (hurt_state == 3'd3) cnt_inv++;
        if (hit_pulse) cnt_hit++;
        if (block_pulse) cnt_blk++;
        if (move_lock) cnt_lock++;
        if (cmp_en) compare_all();
    endtask

    task automatic clear_counts();
        cnt_hs = 0; cnt_bs = 0; cnt_inv = 0; cnt_hit = 0; cnt_blk = 0; cnt_lock = 0;
    endtask

    task automatic do_reset();
        reset = 1; SCEN = 1; hit_enable = 1; opp_attack_active = 0;
        opp_attack_type = 2'd0; overlap = 0; blocking = 0;
        cyc();
        reset = 0;
    endtask

    task automatic wait_phase(input int p, input int bound);
        int n = 0;
        while (m.phase != p) begin
            if (n >= bound) begin
                check("wait_phase_timeout", m.phase, p);
                return;
            end
            cyc();
            n++;
        end
    endtask

    task automatic wait_settle();
        int n = 0;
        while (!(m.phase == 0 || m.phase == 4)) begin
            if (n >= 200) begin
                check("settle_timeout", m.phase, 0);
                return;
            end
            cyc();
            n++;
        end
    endtask

    task automatic hit(input logic [1:0] t, input bit b, input int frames);
        opp_attack_active = 1; opp_attack_type = t; overlap = 1; blocking = b;
        repeat (frames) cyc();
        opp_attack_active = 0;
        cyc();
        wait_settle();
        blocking = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int f, h;
        reset = 1; SCEN = 0; hit_enable = 1; opp_attack_active = 0;
        opp_attack_type = 2'd0; overlap = 0; blocking = 0;
        cyc();
        cmp_en = 1;
        do_reset();
        check("reset_health", 32'(health), 100);
        check("reset_state", 32'(hurt_state), 0);

        // Unblocked ATK1 held for 7 active frames
        clear_counts();
        hit(2'd1, 0, 7);
        check("atk1_health", 32'(health), 92);
        check("atk1_model_health", m.health, 92);
        check("atk1_hit_pulses", cnt_hit, 1);
        check("atk1_hitstun_len", cnt_hs, 12);
        check("atk1_invuln_len", cnt_inv, 30);

        // Blocked ATK2
        do_reset();
        clear_counts();
        hit(2'd2, 1, 3);
        check("blk_health", 32'(health), 97);
        check("blk_model_health", m.health, 97);
        check("blk_pulses", cnt_blk, 1);
        check("blk_len", cnt_bs, 6);
        check("blk_lock_len", cnt_lock, 6);

        // Second attack during INVULN held across the INVULN->IDLE boundary
        do_reset();
        opp_attack_active = 1; opp_attack_type = 2'd1; overlap = 1; cyc();
        opp_attack_active = 0; cyc();
        wait_phase(3, 100);
        opp_attack_active = 1; opp_attack_type = 2'd2;
        wait_phase(0, 100);
        repeat (5) cyc();
        check("invuln_no_damage", 32'(health), 92);
        opp_attack_active = 0; cyc();
        opp_attack_active = 1; cyc();
        check("rearm_hit_health", 32'(health), 77);
        check("rearm_model_health", m.health, 77);
        opp_attack_active = 0; cyc();
        wait_settle();

        // hit_enable low for 5 SCEN mid-HITSTUN
        do_reset();
        clear_counts();
        opp_attack_active = 1; opp_attack_type = 2'd1; overlap = 1; cyc();
        opp_attack_active = 0;
        repeat (4) cyc();
        f = stun_frame; h = health;
        hit_enable = 0;
        repeat (5) cyc();
        check("freeze_frame", 32'(stun_frame), f);
        check("freeze_health", 32'(health), h);
        hit_enable = 1;
        wait_settle();
        check("freeze_hitstun_len", cnt_hs, 17);

        // Reset at HITSTUN frame 7 with health 60
        do_reset();
        repeat (4) hit(2'd1, 0, 1);
        opp_attack_active = 1; opp_attack_type = 2'd1; overlap = 1; cyc();
        opp_attack_active = 0;
        while (m.frame != 7 && m.phase == 1) cyc();
        check("pre_reset_health", 32'(health), 60);
        check("pre_reset_frame", 32'(stun_frame), 7);
        reset = 1; cyc(); reset = 0;
        check("mid_reset_health", 32'(health), 100);
        check("mid_reset_state", 32'(hurt_state), 0);
        check("mid_reset_frame", 32'(stun_frame), 0);
        check("mid_reset_pulses", 32'({hit_pulse, block_pulse, ko}), 0);

        // KO from health 10 and stickiness
        do_reset();
        repeat (6) hit(2'd2, 0, 2);
        check("pre_ko_health", 32'(health), 10);
        opp_attack_active = 1; opp_attack_type = 2'd2; overlap = 1; cyc();
        check("ko_pulse", 32'(hit_pulse), 1);
        check("ko_flag", 32'(ko), 1);
        check("ko_state", 32'(hurt_state), 4);
        check("ko_health", 32'(health), 0);
        opp_attack_active = 0; cyc();
        hit(2'd1, 0, 3);
        hit(2'd2, 1, 3);
        repeat (20) cyc();
        check("ko_sticky_health", 32'(health), 0);
        check("ko_sticky_state", 32'(hurt_state), 4);

        // Chip damage floors at 1
        do_reset();
        repeat (6) hit(2'd2, 0, 2);
        hit(2'd1, 0, 2);
        check("chip_pre_health", 32'(health), 2);
        hit(2'd2, 1, 2);
        check("chip_health", 32'(health), 1);
        check("chip_no_ko", 32'(ko), 0);

        // Randomized traffic
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            reset = ($urandom_range(0, 299) == 0);
            SCEN = ($urandom_range(0, 2) != 0);
            hit_enable = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 5) == 0) opp_attack_active = ~opp_attack_active;
            if ($urandom_range(0, 7) == 0) opp_attack_type = 2'($urandom_range(0, 3));
            overlap = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 9) == 0) blocking = ~blocking;
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
